// File: rtl/cam_dvp_capture.sv
// OV5640 DVP capture front end: packs byte pairs into RGB565 words for SDRAM
// write port 1, skipping sensor settling frames and reloading the FIFO per frame.
module cam_dvp_capture #(
    parameter int DSIZE       = 16,
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10,
    parameter int LOAD_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CAP_EN,
    input  logic             CAM_VSYNC,
    input  logic             CAM_HREF,
    input  logic [7:0]       CAM_DATA,
    output logic [DSIZE-1:0] WR_DATA,
    output logic             WR_EN,
    output logic             WR_LOAD,
    output logic             FRAME_DONE,
    output logic [7:0]       FRAME_CNT,
    output logic             LINE_ERR
);

    localparam int PW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [PW-1:0] PIX_MAX   = PW'(H_ACTIVE);
    localparam logic [LW-1:0] LINE_MAX  = LW'(V_ACTIVE);
    localparam logic [7:0]    SKIP_INIT = 8'(SKIP_FRAMES);
    localparam logic [3:0]    LOAD_MAX  = 4'(LOAD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_LOAD,
        ST_CAPTURE
    } state_t;

    state_t          state_q, state_d;
    logic            vsync_r1_q, vsync_r2_q;
    logic            href_r1_q, href_r2_q;
    logic [7:0]      data_r1_q;
    logic            cap_en_q;
    logic [7:0]      skip_cnt_q, skip_cnt_d;
    logic [3:0]      load_cnt_q, load_cnt_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]   line_cnt_q, line_cnt_d;
    logic            phase_q, phase_d;
    logic [7:0]      hi_byte_q, hi_byte_d;
    logic [DSIZE-1:0] wr_data_q, wr_data_d;
    logic            wr_en_q, wr_en_d;
    logic            wr_load_q, wr_load_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            line_err_q, line_err_d;

    logic vs_rise;
    logic href_fall;
    logic enter_load;

    assign vs_rise   = vsync_r1_q & ~vsync_r2_q;
    assign href_fall = href_r2_q & ~href_r1_q;

    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        load_cnt_d   = load_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        phase_d      = phase_q;
        hi_byte_d    = hi_byte_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        wr_load_d    = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        line_err_d   = line_err_q;
        enter_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CAP_EN) begin
                    skip_cnt_d = SKIP_INIT;
                    state_d    = ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (!CAP_EN) begin
                    state_d = ST_IDLE;
                end else if (vs_rise) begin
                    if (skip_cnt_q == 8'd0) begin
                        enter_load = 1'b1;
                    end else begin
                        skip_cnt_d = skip_cnt_q - 8'd1;
                    end
                end
            end
            ST_LOAD: begin
                if (!CAP_EN) begin
                    state_d = ST_IDLE;
                end else if (load_cnt_q == LOAD_MAX) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wr_load_d  = 1'b1;
                    load_cnt_d = load_cnt_q + 4'd1;
                end
            end
            ST_CAPTURE: begin
                // Phase 1 completes a pixel; words beyond the active window are dropped.
                if (href_r1_q) begin
                    if (!phase_q) begin
                        hi_byte_d = data_r1_q;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (pix_cnt_q < PIX_MAX && line_cnt_q < LINE_MAX) begin
                            wr_data_d = DSIZE'({hi_byte_q, data_r1_q});
                            wr_en_d   = 1'b1;
                            pix_cnt_d = pix_cnt_q + PW'(1);
                        end
                    end
                end else begin
                    phase_d = 1'b0;
                    if (href_fall) begin
                        pix_cnt_d = '0;
                        if (line_cnt_q < LINE_MAX) begin
                            line_cnt_d = line_cnt_q + LW'(1);
                        end
                        if (phase_q) begin
                            line_err_d = 1'b1;
                        end
                    end
                end
                if (vs_rise) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    if (CAP_EN) begin
                        enter_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_load) begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            phase_d    = 1'b0;
        end

        if (cap_en_q && !CAP_EN) begin
            line_err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            vsync_r1_q   <= 1'b0;
            vsync_r2_q   <= 1'b0;
            href_r1_q    <= 1'b0;
            href_r2_q    <= 1'b0;
            data_r1_q    <= '0;
            cap_en_q     <= 1'b0;
            skip_cnt_q   <= '0;
            load_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            phase_q      <= 1'b0;
            hi_byte_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_load_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_r1_q   <= CAM_VSYNC;
            vsync_r2_q   <= vsync_r1_q;
            href_r1_q    <= CAM_HREF;
            href_r2_q    <= href_r1_q;
            data_r1_q    <= CAM_DATA;
            cap_en_q     <= CAP_EN;
            skip_cnt_q   <= skip_cnt_d;
            load_cnt_q   <= load_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            phase_q      <= phase_d;
            hi_byte_q    <= hi_byte_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            wr_load_q    <= wr_load_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            line_err_q   <= line_err_d;
        end
    end

    assign WR_DATA    = wr_data_q;
    assign WR_EN      = wr_en_q;
    assign WR_LOAD    = wr_load_q;
    assign FRAME_DONE = frame_done_q;
    assign FRAME_CNT  = frame_cnt_q;
    assign LINE_ERR   = line_err_q;

endmodule

// File: tb/tb_cam_dvp_capture.sv
// Scoreboard bench for cam_dvp_capture: expected words are queued as DVP bytes
// are driven and matched (data and strobe cycle) whenever WR_EN appears.
module tb_cam_dvp_capture;

    localparam int H_ACT = 4;
    localparam int V_ACT = 2;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        cap_en    = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href  = 1'b0;
    logic [7:0]  cam_data  = 8'h00;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        wr_load;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        line_err;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int load_high   = 0;
    int load_rises  = 0;
    int done_pulses = 0;
    int word_total  = 0;
    logic wr_load_prev = 1'b0;

    bit model_capturing = 1'b0;
    int model_line      = 0;

    logic [7:0] line_a [12];
    logic [7:0] line_b [12];
    logic [7:0] line_c [12];

    cam_dvp_capture #(
        .DSIZE      (16),
        .H_ACTIVE   (H_ACT),
        .V_ACTIVE   (V_ACT),
        .SKIP_FRAMES(1),
        .LOAD_CYCLES(4)
    ) dut (
        .CLK       (clk),
        .RESET_N   (reset_n),
        .CAP_EN    (cap_en),
        .CAM_VSYNC (cam_vsync),
        .CAM_HREF  (cam_href),
        .CAM_DATA  (cam_data),
        .WR_DATA   (wr_data),
        .WR_EN     (wr_en),
        .WR_LOAD   (wr_load),
        .FRAME_DONE(frame_done),
        .FRAME_CNT (frame_cnt),
        .LINE_ERR  (line_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Output monitor: tallies strobes and pulses, pops the scoreboard on each word.
    always @(negedge clk) begin
        if (wr_load) load_high++;
        if (wr_load && !wr_load_prev) load_rises++;
        wr_load_prev = wr_load;
        if (frame_done) done_pulses++;
        if (wr_en) begin
            word_total++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_wr_en", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("wr_data", {16'h0, wr_data}, {16'h0, e.data});
                checkOutput("wr_latency", cyc, e.cyc);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] bytes [12], input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = bytes[i];
            if ((i % 2 == 1) && model_capturing && (i / 2) < H_ACT && model_line < V_ACT) begin
                exp_t e;
                e.data = {bytes[i-1], bytes[i]};
                e.cyc  = cyc + 2;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (4) @(negedge clk);
        model_line++;
    endtask

    task automatic pulseVsync();
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (3) @(negedge clk);
        cam_vsync = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s_load;
        int s_rise;
        int s_done;
        int s_words;
        bit seen;

        line_a = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
        line_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        line_c = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        repeat (3) @(negedge clk);
        checkOutput("rst_wr_en", {31'h0, wr_en}, 32'd0);
        checkOutput("rst_wr_load", {31'h0, wr_load}, 32'd0);
        checkOutput("rst_frame_done", {31'h0, frame_done}, 32'd0);
        checkOutput("rst_frame_cnt", {24'h0, frame_cnt}, 32'd0);
        checkOutput("rst_line_err", {31'h0, line_err}, 32'd0);
        checkOutput("rst_wr_data", {16'h0, wr_data}, 32'd0);
        reset_n = 1'b1;

        // Skip one settling frame, then load.
        @(negedge clk);
        cap_en = 1'b1;
        repeat (3) @(negedge clk);
        s_load = load_high; s_words = word_total;
        pulseVsync();
        repeat (6) @(negedge clk);
        applyStimulus(line_a, 8);
        checkOutput("skip_no_load", load_high - s_load, 32'd0);
        checkOutput("skip_no_wr_en", word_total - s_words, 32'd0);

        s_load = load_high; s_rise = load_rises;
        pulseVsync();
        repeat (10) @(negedge clk);
        checkOutput("load_cycles", load_high - s_load, 32'd4);
        checkOutput("load_single_pulse", load_rises - s_rise, 32'd1);

        // Packing, overlength line and extra line in one frame.
        model_capturing = 1'b1;
        model_line = 0;
        s_words = word_total;
        applyStimulus(line_a, 8);
        checkOutput("pack_words", word_total - s_words, 32'd4);
        checkOutput("pack_drain", sb.size(), 32'd0);
        applyStimulus(line_b, 12);
        applyStimulus(line_a, 8);
        checkOutput("frame_words", word_total - s_words, 32'd8);
        checkOutput("frame_drain", sb.size(), 32'd0);
        checkOutput("even_line_err", {31'h0, line_err}, 32'd0);

        // Frame close with capture still enabled.
        s_load = load_high; s_done = done_pulses;
        pulseVsync();
        repeat (10) @(negedge clk);
        checkOutput("close_done", done_pulses - s_done, 32'd1);
        checkOutput("close_cnt", {24'h0, frame_cnt}, 32'd1);
        checkOutput("close_load", load_high - s_load, 32'd4);

        // Odd line sets the sticky error; a later even line keeps it.
        model_line = 0;
        s_words = word_total;
        applyStimulus(line_a, 7);
        checkOutput("odd_words", word_total - s_words, 32'd3);
        checkOutput("odd_line_err", {31'h0, line_err}, 32'd1);
        applyStimulus(line_c, 4);
        checkOutput("odd_then_even_words", word_total - s_words, 32'd5);
        checkOutput("line_err_sticky", {31'h0, line_err}, 32'd1);

        // Disable inside CAPTURE: frame finishes, then IDLE without reload.
        cap_en = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("line_err_cleared", {31'h0, line_err}, 32'd0);
        s_load = load_high; s_done = done_pulses;
        pulseVsync();
        repeat (10) @(negedge clk);
        checkOutput("stop_done", done_pulses - s_done, 32'd1);
        checkOutput("stop_cnt", {24'h0, frame_cnt}, 32'd2);
        checkOutput("stop_no_load", load_high - s_load, 32'd0);
        model_capturing = 1'b0;
        s_words = word_total;
        applyStimulus(line_a, 8);
        checkOutput("idle_no_words", word_total - s_words, 32'd0);

        // Reset during the second WR_LOAD cycle.
        cap_en = 1'b1;
        repeat (3) @(negedge clk);
        pulseVsync();
        repeat (4) @(negedge clk);
        cam_vsync = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wr_load) seen = 1'b1;
        end
        checkOutput("load_wait", {31'h0, seen}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        cam_vsync = 1'b0;
        #1;
        checkOutput("rst_mid_wr_load", {31'h0, wr_load}, 32'd0);
        checkOutput("rst_mid_frame_cnt", {24'h0, frame_cnt}, 32'd0);
        checkOutput("rst_mid_wr_en", {31'h0, wr_en}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        s_load = load_high;
        pulseVsync();
        repeat (6) @(negedge clk);
        checkOutput("reskip_no_load", load_high - s_load, 32'd0);
        s_load = load_high;
        pulseVsync();
        repeat (10) @(negedge clk);
        checkOutput("reskip_load", load_high - s_load, 32'd4);
        model_capturing = 1'b1;
        model_line = 0;
        s_words = word_total;
        applyStimulus(line_c, 4);
        checkOutput("after_reset_words", word_total - s_words, 32'd2);
        checkOutput("final_drain", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
